// File: rtl/card_dispatch_arbiter_if.sv
// card_dispatch_arbiter_if: game-side, hand-side and deck-side signals of the card dispatch arbiter.
interface card_dispatch_arbiter_if #(
    parameter int CARD_W = 4
);
    logic              i_deal_start;
    logic              i_player_req;
    logic              i_dealer_req;
    logic [2:0]        i_player_count;
    logic [2:0]        i_dealer_count;
    logic              i_reveal;
    logic              o_deck_req;
    logic              i_deck_valid;
    logic [CARD_W-1:0] i_deck_card;
    logic [CARD_W-1:0] o_card;
    logic              o_player_we;
    logic              o_dealer_we;
    logic              o_player_ack;
    logic              o_dealer_ack;
    logic              o_player_nack;
    logic              o_dealer_nack;
    logic              o_hole_hidden;
    logic              o_deal_done;
    logic              o_busy;
    logic              o_error;

    modport slave (
        input  i_deal_start, i_player_req, i_dealer_req, i_player_count, i_dealer_count,
               i_reveal, i_deck_valid, i_deck_card,
        output o_deck_req, o_card, o_player_we, o_dealer_we, o_player_ack, o_dealer_ack,
               o_player_nack, o_dealer_nack, o_hole_hidden, o_deal_done, o_busy, o_error
    );

    modport master (
        output i_deal_start, i_player_req, i_dealer_req, i_player_count, i_dealer_count,
               i_reveal, i_deck_valid, i_deck_card,
        input  o_deck_req, o_card, o_player_we, o_dealer_we, o_player_ack, o_dealer_ack,
               o_player_nack, o_dealer_nack, o_hole_hidden, o_deal_done, o_busy, o_error
    );
endinterface

// File: rtl/card_dispatch_arbiter.sv
// card_dispatch_arbiter: sole owner of the deck draw port; sequences the opening deal and arbitrates hits.
module card_dispatch_arbiter #(
    parameter int CARD_W    = 4,
    parameter int MAX_CARDS = 5,
    parameter int TIMEOUT   = 16
) (
    input logic                    i_clk,
    input logic                    i_reset,
    card_dispatch_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DELIVER} state_t;

    state_t            state_q, state_d;
    logic              deal_q, deal_d;
    logic [1:0]        idx_q, idx_d;
    logic              rr_q, rr_d;
    logic              tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic              player_we_q, player_we_d;
    logic              dealer_we_q, dealer_we_d;
    logic              player_ack_q, player_ack_d;
    logic              dealer_ack_q, dealer_ack_d;
    logic              player_nack_q, player_nack_d;
    logic              dealer_nack_q, dealer_nack_d;
    logic              hole_q, hole_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    // rr_q / tgt_q: 1 means dealer. Ties go to whoever was not granted last.
    logic grant_dealer, grant_full, dlv_dealer;
    assign grant_dealer = bus.i_dealer_req & (~bus.i_player_req | ~rr_q);
    assign grant_full   = grant_dealer ? (32'(bus.i_dealer_count) >= MAX_CARDS)
                                       : (32'(bus.i_player_count) >= MAX_CARDS);
    assign dlv_dealer   = deal_q ? idx_q[0] : tgt_q;

    always_comb begin
        state_d       = state_q;
        deal_d        = deal_q;
        idx_d         = idx_q;
        rr_d          = rr_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        card_d        = card_q;
        player_we_d   = 1'b0;
        dealer_we_d   = 1'b0;
        player_ack_d  = 1'b0;
        dealer_ack_d  = 1'b0;
        player_nack_d = 1'b0;
        dealer_nack_d = 1'b0;
        done_d        = 1'b0;
        hole_d        = hole_q & ~bus.i_reveal;
        error_d       = error_q;
        case (state_q)
            IDLE: begin
                if (bus.i_deal_start) begin
                    deal_d  = 1'b1;
                    idx_d   = 2'd0;
                    hole_d  = 1'b0;
                    state_d = REQ;
                end else if (bus.i_player_req | bus.i_dealer_req) begin
                    rr_d = grant_dealer;
                    if (grant_full) begin
                        player_nack_d = ~grant_dealer;
                        dealer_nack_d = grant_dealer;
                    end else begin
                        tgt_d   = grant_dealer;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_deck_valid) begin
                    card_d       = bus.i_deck_card;
                    player_we_d  = ~dlv_dealer;
                    dealer_we_d  = dlv_dealer;
                    player_ack_d = ~deal_q & ~dlv_dealer;
                    dealer_ack_d = ~deal_q & dlv_dealer;
                    state_d      = DELIVER;
                    if (deal_q && idx_q == 2'd3) begin
                        hole_d = 1'b1;
                        done_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    deal_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DELIVER: begin
                if (deal_q && idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = REQ;
                end else begin
                    deal_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            deal_q        <= 1'b0;
            idx_q         <= 2'd0;
            rr_q          <= 1'b1;
            tgt_q         <= 1'b0;
            cnt_q         <= '0;
            card_q        <= '0;
            player_we_q   <= 1'b0;
            dealer_we_q   <= 1'b0;
            player_ack_q  <= 1'b0;
            dealer_ack_q  <= 1'b0;
            player_nack_q <= 1'b0;
            dealer_nack_q <= 1'b0;
            hole_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            deal_q        <= deal_d;
            idx_q         <= idx_d;
            rr_q          <= rr_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            card_q        <= card_d;
            player_we_q   <= player_we_d;
            dealer_we_q   <= dealer_we_d;
            player_ack_q  <= player_ack_d;
            dealer_ack_q  <= dealer_ack_d;
            player_nack_q <= player_nack_d;
            dealer_nack_q <= dealer_nack_d;
            hole_q        <= hole_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.o_deck_req    = state_q == REQ;
    assign bus.o_busy        = state_q != IDLE;
    assign bus.o_card        = card_q;
    assign bus.o_player_we   = player_we_q;
    assign bus.o_dealer_we   = dealer_we_q;
    assign bus.o_player_ack  = player_ack_q;
    assign bus.o_dealer_ack  = dealer_ack_q;
    assign bus.o_player_nack = player_nack_q;
    assign bus.o_dealer_nack = dealer_nack_q;
    assign bus.o_hole_hidden = hole_q;
    assign bus.o_deal_done   = done_q;
    assign bus.o_error       = error_q;
endmodule

// File: tb/tb_card_dispatch_arbiter.sv
// tb_card_dispatch_arbiter: directed scenarios plus randomized hits checked against a transaction-level model.
module tb_card_dispatch_arbiter;
    localparam int CARD_W    = 4;
    localparam int MAX_CARDS = 5;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   m_last_dealer = 1'b1;
    int   n_req = 0;
    int   n_pwe = 0;
    int   n_dwe = 0;
    int   n_pack = 0;
    int   n_dack = 0;

    card_dispatch_arbiter_if #(.CARD_W(CARD_W)) bus ();

    card_dispatch_arbiter #(.CARD_W(CARD_W), .MAX_CARDS(MAX_CARDS), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_deck_req === 1'b1) n_req++;
        if (bus.o_player_we === 1'b1) n_pwe++;
        if (bus.o_dealer_we === 1'b1) n_dwe++;
        if (bus.o_player_ack === 1'b1) n_pack++;
        if (bus.o_dealer_ack === 1'b1) n_dack++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.o_deck_req, bus.o_card, bus.o_player_we, bus.o_dealer_we,
                    bus.o_player_ack, bus.o_dealer_ack, bus.o_player_nack, bus.o_dealer_nack,
                    bus.o_hole_hidden, bus.o_deal_done, bus.o_busy, bus.o_error});
    endfunction

    task automatic clear_inputs();
        bus.i_deal_start   = 1'b0;
        bus.i_player_req   = 1'b0;
        bus.i_dealer_req   = 1'b0;
        bus.i_player_count = 3'd0;
        bus.i_dealer_count = 3'd0;
        bus.i_reveal       = 1'b0;
        bus.i_deck_valid   = 1'b0;
        bus.i_deck_card    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;
        m_last_dealer = 1'b1;
        tick();
    endtask

    // One hit transaction from IDLE; the model decides the grant from the arbitration rule.
    task automatic hit_txn(input string tag, input bit p, input bit d, input logic [2:0] pc,
                           input logic [2:0] dc, input int dly, input logic [3:0] card,
                           output bit served_dealer);
        bit g;
        bit full;
        int w0;
        g = (p && d) ? !m_last_dealer : d;
        m_last_dealer = g;
        full = int'(g ? dc : pc) >= MAX_CARDS;
        bus.i_player_req   = p;
        bus.i_dealer_req   = d;
        bus.i_player_count = pc;
        bus.i_dealer_count = dc;
        w0 = n_pwe + n_dwe;
        tick();
        if (full) begin
            chk({tag, "_nack"}, {bus.o_player_nack, bus.o_dealer_nack}, {!g, g});
            chk({tag, "_nodraw"}, {bus.o_deck_req, bus.o_busy}, 0);
            served_dealer = bus.o_dealer_nack;
            bus.i_player_req = 1'b0;
            bus.i_dealer_req = 1'b0;
            tick();
            chk({tag, "_nack_pulse"}, {bus.o_player_nack, bus.o_dealer_nack, bus.o_deck_req}, 0);
            chk({tag, "_no_we"}, n_pwe + n_dwe, w0);
        end else begin
            chk({tag, "_req"}, bus.o_deck_req, 1);
            tick();
            repeat (dly - 1) tick();
            bus.i_deck_valid = 1'b1;
            bus.i_deck_card  = card;
            tick();
            bus.i_deck_valid = 1'b0;
            chk({tag, "_we_ack"},
                {bus.o_player_we, bus.o_dealer_we, bus.o_player_ack, bus.o_dealer_ack},
                {!g, g, !g, g});
            chk({tag, "_card"}, bus.o_card, card);
            served_dealer = bus.o_dealer_we;
            bus.i_player_req = 1'b0;
            bus.i_dealer_req = 1'b0;
            tick();
            chk({tag, "_end"},
                {bus.o_player_we, bus.o_dealer_we, bus.o_player_ack, bus.o_dealer_ack, bus.o_busy}, 0);
            chk({tag, "_card_hold"}, bus.o_card, card);
        end
    endtask

    initial begin
        logic [3:0] cards [4];
        bit         sd;
        int         r0, a0, d0, w0;
        time        t0, t4;
        cards = '{4'd3, 4'd10, 4'd7, 4'd1};
        clear_inputs();
        do_reset();

        // Opening deal, with a dealer hit raised at index 1 and a stray deal_start while busy.
        r0 = n_req;
        a0 = n_pack + n_dack;
        d0 = n_dack;
        t0 = $time;
        bus.i_deal_start = 1'b1;
        tick();
        bus.i_deal_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("deal_req", bus.o_deck_req, 1);
            if (i == 2) bus.i_deal_start = 1'b1;
            tick();
            bus.i_deal_start = 1'b0;
            if (i == 1) bus.i_dealer_req = 1'b1;
            if (i == 3) bus.i_reveal = 1'b1;
            bus.i_deck_valid = 1'b1;
            bus.i_deck_card  = cards[i];
            tick();
            bus.i_deck_valid = 1'b0;
            bus.i_reveal     = 1'b0;
            chk("deal_we", {bus.o_player_we, bus.o_dealer_we}, {i[0] == 1'b0, i[0] == 1'b1});
            chk("deal_card", bus.o_card, cards[i]);
            chk("deal_no_ack", {bus.o_player_ack, bus.o_dealer_ack}, 0);
            chk("deal_done", {bus.o_deal_done, bus.o_hole_hidden}, {i == 3, i == 3});
            if (i == 3) begin
                t4 = $time;
                chk("deal_len", 32'((t4 - t0) / 10), 12);
                chk("deal_req_cnt", n_req - r0, 4);
                chk("deal_acks", n_pack + n_dack - a0, 0);
                chk("mid_deal_dealer_not_acked", n_dack - d0, 0);
            end
            tick();
        end
        chk("deal_done_pulse", bus.o_deal_done, 0);
        tick();
        chk("held_dealer_req", bus.o_deck_req, 1);
        tick();
        bus.i_deck_valid = 1'b1;
        bus.i_deck_card  = 4'd9;
        tick();
        bus.i_deck_valid = 1'b0;
        chk("held_dealer_ack", {bus.o_dealer_we, bus.o_dealer_ack, bus.o_player_we}, 3'b110);
        chk("held_dealer_card", bus.o_card, 9);
        bus.i_dealer_req = 1'b0;
        m_last_dealer = 1'b1;
        tick();
        chk("hole_still_hidden", bus.o_hole_hidden, 1);
        bus.i_reveal = 1'b1;
        tick();
        bus.i_reveal = 1'b0;
        chk("reveal_clears", bus.o_hole_hidden, 0);

        // Simultaneous requests from reset alternate P, D, P, D.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hit_txn("tie", 1'b1, 1'b1, 3'd0, 3'd0, 1, 4'(i + 2), sd);
            chk("tie_alternation", sd, i[0]);
        end

        // Full hand is refused; one below full is served.
        hit_txn("full_p", 1'b1, 1'b0, 3'd5, 3'd0, 1, 4'd4, sd);
        hit_txn("full_d", 1'b0, 1'b1, 3'd0, 3'd7, 1, 4'd4, sd);
        hit_txn("almost_full", 1'b1, 1'b0, 3'd4, 3'd0, 2, 4'd11, sd);
        hit_txn("valid_last_wait", 1'b0, 1'b1, 3'd0, 3'd0, TIMEOUT, 4'd13, sd);

        // Deck timeout: valid never arrives.
        w0 = n_pwe;
        bus.i_player_req = 1'b1;
        m_last_dealer = 1'b0;
        tick();
        chk("to_req", bus.o_deck_req, 1);
        bus.i_player_req = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("to_not_yet", {bus.o_error, bus.o_busy}, 2'b01);
        tick();
        chk("to_error", {bus.o_error, bus.o_busy, bus.o_player_we, bus.o_player_ack}, 4'b1000);
        tick();
        chk("to_no_we", n_pwe - w0, 0);
        hit_txn("after_to", 1'b1, 1'b0, 3'd1, 3'd0, 3, 4'd6, sd);
        chk("error_sticky", bus.o_error, 1);

        // Asynchronous reset while waiting for the deck; the late card is ignored.
        w0 = n_pwe + n_dwe;
        bus.i_dealer_req = 1'b1;
        tick();
        bus.i_dealer_req = 1'b0;
        tick();
        chk("ar_in_wait", bus.o_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_async_outs", all_outs(), 0);
        tick();
        rst = 1'b0;
        m_last_dealer = 1'b1;
        bus.i_deck_valid = 1'b1;
        bus.i_deck_card  = 4'd5;
        tick();
        bus.i_deck_valid = 1'b0;
        tick();
        tick();
        chk("ar_outs_after", all_outs(), 0);
        chk("ar_no_we", n_pwe + n_dwe - w0, 0);

        // Randomized hits against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            bit p, d;
            p = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!p && !d) p = 1'b1;
            hit_txn("rand", p, d, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)),
                    int'($urandom_range(1, TIMEOUT)), 4'($urandom_range(0, 15)), sd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
